// File: rtl/ulpi_rx_packetizer.sv
// ulpi_rx_packetizer: frames ULPI RX bytes into packets held in a commit/rollback FIFO.
// Optional ULPI_RX_PKT_STATS_EN adds saturating good_count/drop_count outputs. Rev 1.0
`default_nettype none

module ulpi_rx_packetizer #(
  parameter int DEPTH_LOG2  = 9,
  parameter int MAX_PKT_LEN = 1027
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sys_data,
  input  logic       sys_data_valid,
  input  logic [7:0] sys_rx_cmd,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_done,
  output logic       pkt_drop
`ifdef ULPI_RX_PKT_STATS_EN
  ,
  output logic [15:0] good_count,
  output logic [15:0] drop_count
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [PW-1:0] CAP = PW'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} state_t;

  state_t          state;
  logic [8:0]      mem [0:(2**DEPTH_LOG2)-1];
  logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [LW-1:0]   len;
  logic [7:0]      held_data;
  logic            held_valid;
  logic            rx_active_r;

  logic            rx_active, rx_error, rx_start, rx_end;
  logic [PW-1:0]   free, free_n, wr_ptr_n;
  logic            accept, overflow, push, held_valid_n, commit_ok;
  logic [7:0]      held_data_n;

  assign rx_active = sys_rx_cmd[4];
  assign rx_error  = (sys_rx_cmd[5:4] == 2'b11);
  assign rx_start  = rx_active & ~rx_active_r;
  assign rx_end    = ~rx_active & rx_active_r;
  assign free      = CAP - (wr_ptr - rd_ptr);

  // The incoming byte is folded in first; end-of-packet then sees it as the held byte.
  always_comb begin
    accept       = (state == RECV) && sys_data_valid && (len != LW'(MAX_PKT_LEN))
                   && !(held_valid && (free == '0));
    overflow     = (state == RECV) && sys_data_valid && !accept;
    push         = accept && held_valid;
    held_valid_n = accept | held_valid;
    held_data_n  = accept ? sys_data : held_data;
    wr_ptr_n     = wr_ptr + PW'(push);
    free_n       = free - PW'(push);
    commit_ok    = (state == RECV) && rx_end && !overflow && held_valid_n && (free_n != '0);
  end

  // Two write ports: a same-cycle byte plus end needs both the held byte and the final byte stored.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {1'b0, held_data};
    if (commit_ok)
      mem[wr_ptr_n[DEPTH_LOG2-1:0]] <= {1'b1, held_data_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      held_data   <= '0;
      held_valid  <= 1'b0;
      rx_active_r <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_drop    <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      pkt_drop    <= 1'b0;
      rx_active_r <= rx_active;
      if (out_valid && out_ready)
        rd_ptr <= rd_ptr + PW'(1);
      case (state)
        IDLE: begin
          if (rx_start) begin
            state      <= RECV;
            len        <= '0;
            held_valid <= 1'b0;
            wr_ptr     <= commit_ptr;
          end
        end
        RECV: begin
          if (overflow || rx_error) begin
            state      <= DISCARD;
            wr_ptr     <= commit_ptr;
            held_valid <= 1'b0;
          end else begin
            if (accept) begin
              held_data  <= sys_data;
              held_valid <= 1'b1;
              len        <= len + LW'(1);
            end
            wr_ptr <= wr_ptr_n;
            if (rx_end) begin
              state      <= IDLE;
              held_valid <= 1'b0;
              if (commit_ok) begin
                commit_ptr <= wr_ptr_n + PW'(1);
                wr_ptr     <= wr_ptr_n + PW'(1);
                pkt_done   <= 1'b1;
              end else if (held_valid_n) begin
                wr_ptr   <= commit_ptr;
                pkt_drop <= 1'b1;
              end
            end
          end
        end
        DISCARD: begin
          if (!rx_active) begin
            pkt_drop <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (rd_ptr != commit_ptr);
  assign out_data  = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]][7:0] : 8'h00;
  assign out_last  = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]][8]   : 1'b0;

`ifdef ULPI_RX_PKT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_count <= '0;
      drop_count <= '0;
    end else begin
      if (pkt_done && (good_count != 16'hFFFF))
        good_count <= good_count + 16'd1;
      if (pkt_drop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ulpi_rx_packetizer.sv
// tb_ulpi_rx_packetizer: directed packet vectors against a hand-built expected byte queue.
`default_nettype none

module tb_ulpi_rx_packetizer;

  localparam int DL = 4;
  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sys_data = 8'h00;
  logic       sys_data_valid = 1'b0;
  logic [7:0] sys_rx_cmd = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last, out_valid, pkt_done, pkt_drop;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int ready_mode = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pk[$];

  ulpi_rx_packetizer #(.DEPTH_LOG2(DL), .MAX_PKT_LEN(ML)) dut (
    .clk(clk), .reset_n(reset_n), .sys_data(sys_data), .sys_data_valid(sys_data_valid),
    .sys_rx_cmd(sys_rx_cmd), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_done(pkt_done), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: drive out_ready, count pulses, compare each accepted byte.
  initial forever begin
    @(negedge clk);
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
    if (pkt_done) done_cnt++;
    if (pkt_drop) drop_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_rd", exp_q.size(), 1);
      else check("rd_byte", {23'b0, out_last, out_data}, {23'b0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mk(input logic [7:0] base, input int n);
    pk.delete();
    for (int i = 0; i < n; i++) pk.push_back(base + 8'(i));
  endtask

  task automatic expect_pkt();
    for (int i = 0; i < pk.size(); i++) exp_q.push_back({(i == pk.size() - 1), pk[i]});
  endtask

  task automatic send_pkt(input bit same_end);
    @(negedge clk);
    sys_rx_cmd = 8'h10;
    for (int i = 0; i < pk.size(); i++) begin
      @(negedge clk);
      sys_data = pk[i];
      sys_data_valid = 1'b1;
      if (same_end && i == pk.size() - 1) sys_rx_cmd = 8'h00;
    end
    @(negedge clk);
    sys_data_valid = 1'b0;
    sys_rx_cmd = 8'h00;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    cyc(3);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_done", pkt_done, 0);
    check("rst_drop", pkt_drop, 0);
    reset_n = 1'b1;
    cyc(2);

    // Basic 5-byte packet
    ready_mode = 1;
    pk = '{8'hC3, 8'h01, 8'h02, 8'hAA, 8'hBB};
    expect_pkt();
    send_pkt(1'b0);
    cyc(4);
    wait_drain(50);
    check("t1_done", done_cnt, 1);
    check("t1_drop", drop_cnt, 0);

    // RxError mid-packet
    @(negedge clk); sys_rx_cmd = 8'h10;
    @(negedge clk); sys_data = 8'h69; sys_data_valid = 1'b1;
    @(negedge clk); sys_data = 8'h11;
    @(negedge clk); sys_data_valid = 1'b0; sys_rx_cmd = 8'h30;
    @(negedge clk); sys_rx_cmd = 8'h00;
    cyc(1);
    check("t2_valid", out_valid, 0);
    cyc(3);
    check("t2_drop", drop_cnt, 1);
    check("t2_done", done_cnt, 1);
    check("t2_commit", dut.commit_ptr, 5);

    // Fill to exactly full, then overflow a packet
    ready_mode = 0;
    mk(8'h10, 5); expect_pkt(); send_pkt(1'b0);
    mk(8'h20, 7); expect_pkt(); send_pkt(1'b0);
    mk(8'h30, 4); expect_pkt(); send_pkt(1'b0);
    cyc(4);
    check("t3_done", done_cnt, 4);
    check("t3_commit", dut.commit_ptr, 21);
    check("t3_head", {23'b0, out_last, out_data}, 32'h010);
    mk(8'h40, 8); send_pkt(1'b0);
    cyc(4);
    check("t3_drop", drop_cnt, 2);
    check("t3_commit_kept", dut.commit_ptr, 21);
    ready_mode = 1;
    wait_drain(100);

    // Length limit: 9 bytes dropped, 8 bytes accepted
    mk(8'h50, 9); send_pkt(1'b0);
    cyc(3);
    check("t4_drop", drop_cnt, 3);
    mk(8'h60, 8); expect_pkt(); send_pkt(1'b0);
    cyc(3);
    wait_drain(50);
    check("t4_done", done_cnt, 5);

    // Back-to-back packets with a toggling consumer
    ready_mode = 2;
    mk(8'h70, 3); expect_pkt(); send_pkt(1'b0);
    mk(8'h80, 3); expect_pkt(); send_pkt(1'b0);
    cyc(3);
    wait_drain(60);
    check("t5_done", done_cnt, 7);

    // Last byte on the same cycle as end; single-byte and empty packets
    ready_mode = 1;
    mk(8'h90, 5); expect_pkt(); send_pkt(1'b1);
    mk(8'hA0, 1); expect_pkt(); send_pkt(1'b1);
    pk.delete(); send_pkt(1'b0);
    cyc(4);
    wait_drain(50);
    check("t7_done", done_cnt, 9);
    check("t7_drop", drop_cnt, 3);

    // Reset mid-packet with committed data pending
    ready_mode = 0;
    mk(8'hB0, 2); send_pkt(1'b0);
    @(negedge clk); sys_rx_cmd = 8'h10;
    @(negedge clk); sys_data = 8'hD1; sys_data_valid = 1'b1;
    @(negedge clk); sys_data = 8'hD2;
    @(negedge clk); reset_n = 1'b0; sys_data_valid = 1'b0; sys_rx_cmd = 8'h00;
    cyc(2);
    check("t6_valid", out_valid, 0);
    check("t6_drop", pkt_drop, 0);
    check("t6_wr", dut.wr_ptr, 0);
    check("t6_commit", dut.commit_ptr, 0);
    check("t6_rd", dut.rd_ptr, 0);
    reset_n = 1'b1;
    cyc(2);
    ready_mode = 1;
    mk(8'hC0, 4); expect_pkt(); send_pkt(1'b0);
    cyc(3);
    wait_drain(50);
    check("t6_done", done_cnt, 11);
    check("t6_drop_cnt", drop_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
